// File: rtl/shift_pkg.sv
// Shared types for the 6-bit shift register and its upstream sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

  // Shift register width and step-counter width used as parameter defaults
  localparam int SR_WIDTH = 6;
  localparam int SR_AMT_W = 3;

  // 3-bit OP encoding understood by the shift register
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_CLR  = 3'd5,
    OP_LOAD = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  // Sequencer control states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOADING  = 2'd1,
    S_SHIFTING = 2'd2,
    S_DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_cmd_norm.sv
// Normalises a shift command into (load flag, issue op, step count); SHIFT_SHORTCUT_EN enables shortcuts.
// Latency: combinational.
// Backpressure: none; evaluated on the raw command fields, sampled by the sequencer at acceptance.
module shift_cmd_norm
  import shift_pkg::*;
#(
  parameter int AMT_W = SR_AMT_W
`ifdef SHIFT_SHORTCUT_EN
  ,
  parameter int WIDTH = SR_WIDTH
`endif
) (
  input  logic [2:0]       kind,
  input  logic [AMT_W-1:0] amt,
  input  logic             load,
  output logic [AMT_W-1:0] steps,
  output logic [2:0]       issue_op,
  output logic             do_load
);

  // Map the requested kind onto what will actually be issued
  always_comb begin
    steps    = '0;
    issue_op = kind;
    do_load  = load;
    case (op_t'(kind))
      OP_HOLD, OP_RSVD: begin
        // No work at all: the command just produces a done pulse
        issue_op = OP_HOLD;
        do_load  = 1'b0;
      end
      OP_LOAD: begin
        // A bare LOAD is a preload with zero shift steps
        issue_op = OP_HOLD;
        do_load  = 1'b1;
      end
      OP_CLR: begin
        steps = AMT_W'(1);
      end
      OP_SHR, OP_SHL: begin
`ifdef SHIFT_SHORTCUT_EN
        // Shifting out every bit equals a clear, done in a single step
        if (int'(amt) >= WIDTH) begin
          issue_op = OP_CLR;
          steps    = AMT_W'(1);
        end else begin
          steps = amt;
        end
`else
        steps = amt;
`endif
      end
      OP_ROR, OP_ROL: begin
`ifdef SHIFT_SHORTCUT_EN
        // Whole rotations are no-ops, so only the remainder is issued
        steps = AMT_W'(int'(amt) % WIDTH);
`else
        steps = amt;
`endif
      end
      default: begin
        issue_op = OP_HOLD;
        do_load  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Expands one accepted shift command into a per-cycle OP/Data_in stream; build option SHIFT_SHORTCUT_EN.
// Latency: OP non-HOLD for L+N cycles after acceptance, done pulses L+N+1 cycles after acceptance.
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid waits until the cycle after done.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH,
  parameter int AMT_W = SR_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_kind,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       OP,
  output logic [WIDTH-1:0] Data_in,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] lat_steps;
  logic [2:0]       lat_op;

  logic [AMT_W-1:0] n_steps;
  logic [2:0]       n_op;
  logic             n_load;

  shift_cmd_norm #(
    .AMT_W(AMT_W)
`ifdef SHIFT_SHORTCUT_EN
    ,
    .WIDTH(WIDTH)
`endif
  ) u_norm (
    .kind    (cmd_kind),
    .amt     (cmd_amt),
    .load    (cmd_load),
    .steps   (n_steps),
    .issue_op(n_op),
    .do_load (n_load)
  );

  assign cmd_ready = (state == S_IDLE);

  // Control FSM: all outputs registered, done raised on the edge that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_steps <= '0;
      lat_op    <= OP_HOLD;
      OP        <= OP_HOLD;
      Data_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Latch the normalised command; raw fields are ignored from here on
            busy      <= 1'b1;
            lat_steps <= n_steps;
            lat_op    <= n_op;
            if (n_load) begin
              OP      <= OP_LOAD;
              Data_in <= cmd_data;
              state   <= S_LOADING;
            end else if (n_steps != '0) begin
              OP    <= n_op;
              cnt   <= n_steps - AMT_W'(1);
              state <= S_SHIFTING;
            end else begin
              OP    <= OP_HOLD;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_LOADING: begin
          if (lat_steps != '0) begin
            OP    <= lat_op;
            cnt   <= lat_steps - AMT_W'(1);
            state <= S_SHIFTING;
          end else begin
            OP    <= OP_HOLD;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_SHIFTING: begin
          // cnt counts the steps still to issue after the current one
          if (cnt != '0) begin
            cnt <= cnt - AMT_W'(1);
          end else begin
            OP    <= OP_HOLD;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          OP    <= OP_HOLD;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          OP    <= OP_HOLD;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer; also models the downstream shift register (honours SHIFT_SHORTCUT_EN).
// Latency: expects OP stream from the cycle after acceptance and done L+N+1 cycles after acceptance.
// Backpressure: commands are held on cmd_valid until cmd_ready, including back-to-back holds while busy.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_kind;
  logic [2:0] cmd_amt;
  logic       cmd_load;
  logic [5:0] cmd_data;
  logic [2:0] OP;
  logic [5:0] Data_in;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_ops[$];
  logic       exp_load;
  logic [5:0] exp_din;
  logic [5:0] bench_sr = '0;
  logic [5:0] snap;

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_kind (cmd_kind),
    .cmd_amt  (cmd_amt),
    .cmd_load (cmd_load),
    .cmd_data (cmd_data),
    .OP       (OP),
    .Data_in  (Data_in),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Downstream shift register driven by the sequencer outputs
  always @(posedge clk) begin
    case (OP)
      3'd1: bench_sr <= bench_sr >> 1;
      3'd2: bench_sr <= bench_sr << 1;
      3'd3: bench_sr <= {bench_sr[0], bench_sr[5:1]};
      3'd4: bench_sr <= {bench_sr[4:0], bench_sr[5]};
      3'd5: bench_sr <= 6'd0;
      3'd6: bench_sr <= Data_in;
      default: bench_sr <= bench_sr;
    endcase
  end

  // Expected OP stream from the command rules
  function automatic void build_ops(input logic [2:0] k, input logic [2:0] a, input logic l);
    int n;
    logic [2:0] op;
    exp_ops.delete();
    exp_load = l;
    n  = int'(a);
    op = k;
    case (k)
      3'd0, 3'd7: begin exp_load = 1'b0; n = 0; end
      3'd6: begin exp_load = 1'b1; n = 0; end
      3'd5: n = 1;
`ifdef SHIFT_SHORTCUT_EN
      3'd1, 3'd2: if (n >= 6) begin op = 3'd5; n = 1; end
      3'd3, 3'd4: n = n % 6;
`endif
      default: ;
    endcase
    if (exp_load) exp_ops.push_back(3'd6);
    for (int i = 0; i < n; i++) exp_ops.push_back(op);
  endfunction

  // Expected final register value computed arithmetically for the whole command
  function automatic logic [5:0] model_result(input logic [2:0] k, input int a, input logic l,
                                              input logic [5:0] d, input logic [5:0] start);
    int x;
    int r;
    x = int'(start);
    if (k == 3'd6 || (l && k != 3'd0 && k != 3'd7)) x = int'(d);
    r = a % 6;
    case (k)
      3'd1: x = x >> a;
      3'd2: x = (x << a) & 63;
      3'd3: x = ((x >> r) | (x << (6 - r))) & 63;
      3'd4: x = ((x << r) | (x >> (6 - r))) & 63;
      3'd5: x = 0;
      default: ;
    endcase
    return x[5:0];
  endfunction

  // Present a command and wait (bounded) for the accepting edge; starts and ends around a negedge
  task automatic send(input logic [2:0] k, input logic [2:0] a, input logic l, input logic [5:0] d);
    bit ok;
    cmd_kind  = k;
    cmd_amt   = a;
    cmd_load  = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready === 1'b1) begin
        snap = bench_sr;
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready got %b want 1 within 40 cycles", cmd_ready);
    end
  endtask

  // Check the per-cycle stream of one accepted command, then the idle cycle after it
  task automatic check_stream(input logic [2:0] k, input logic [2:0] a, input logic l,
                              input logic [5:0] d, input bit drop, input string tag);
    logic [5:0] want_sr;
    logic [2:0] want_op;
    logic       want_done;
    int total;
    build_ops(k, a, l);
    want_sr = model_result(k, int'(a), l, d, snap);
    if (exp_load) exp_din = d;
    total = exp_ops.size();
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      want_op   = (c <= total) ? exp_ops[c-1] : 3'd0;
      want_done = (c == total + 1);
      n_checks++;
      if (OP !== want_op) begin
        n_fail++;
        $display("FAIL %s op cyc=%0d: got %b want %b", tag, c, OP, want_op);
      end
      n_checks++;
      if (done !== want_done) begin
        n_fail++;
        $display("FAIL %s done cyc=%0d: got %b want %b", tag, c, done, want_done);
      end
      n_checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy/ready cyc=%0d: got %b/%b want 1/0", tag, c, busy, cmd_ready);
      end
      n_checks++;
      if (Data_in !== exp_din) begin
        n_fail++;
        $display("FAIL %s data_in cyc=%0d: got %b want %b", tag, c, Data_in, exp_din);
      end
      if (c == total + 1) begin
        n_checks++;
        if (bench_sr !== want_sr) begin
          n_fail++;
          $display("FAIL %s result: got %b want %b", tag, bench_sr, want_sr);
        end
      end
      if (drop && c == 1) begin
        // Junk on the fields after acceptance must not disturb the stream
        cmd_valid = 1'b0;
        cmd_kind  = 3'($urandom_range(0, 7));
        cmd_amt   = 3'($urandom_range(0, 7));
        cmd_load  = 1'($urandom_range(0, 1));
        cmd_data  = 6'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || OP !== 3'd0) begin
      n_fail++;
      $display("FAIL %s idle_after: got ready=%b busy=%b done=%b op=%b want 1 0 0 000",
               tag, cmd_ready, busy, done, OP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind = '0;
    cmd_amt = '0;
    cmd_load = 1'b0;
    cmd_data = '0;
    exp_din = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (OP !== 3'd0 || Data_in !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got op=%b din=%b busy=%b done=%b want 000 000000 0 0",
               OP, Data_in, busy, done);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    // cmd_valid together with rst must not be accepted
    cmd_kind = 3'd1;
    cmd_amt = 3'd3;
    cmd_load = 1'b1;
    cmd_data = 6'b110011;
    cmd_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || OP !== 3'd0 || Data_in !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_with_valid: got busy=%b op=%b din=%b want 0 000 000000", busy, OP, Data_in);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_command();
    send(3'd1, 3'd7, 1'b0, 6'd0);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (OP !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || Data_in !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got op=%b busy=%b done=%b din=%b want 000 0 0 000000",
               OP, busy, done, Data_in);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_din = '0;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b want 1", cmd_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || OP !== 3'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet cyc=%0d: got done=%b op=%b busy=%b want 0 000 0", i, done, OP, busy);
      end
    end
  endtask

  task automatic test_load_shr();
    send(3'd1, 3'd2, 1'b1, 6'b101011);
    check_stream(3'd1, 3'd2, 1'b1, 6'b101011, 1'b1, "load_shr");
    n_checks++;
    if (bench_sr !== 6'b001010) begin
      n_fail++;
      $display("FAIL load_shr_const: got %b want 001010", bench_sr);
    end
  endtask

  task automatic test_zero_steps();
    send(3'd4, 3'd0, 1'b0, 6'b111000);
    check_stream(3'd4, 3'd0, 1'b0, 6'b111000, 1'b1, "rol_zero");
    send(3'd7, 3'd5, 1'b1, 6'b010101);
    check_stream(3'd7, 3'd5, 1'b1, 6'b010101, 1'b1, "reserved");
    send(3'd6, 3'd4, 1'b0, 6'b100110);
    check_stream(3'd6, 3'd4, 1'b0, 6'b100110, 1'b1, "bare_load");
    send(3'd5, 3'd6, 1'b0, 6'd0);
    check_stream(3'd5, 3'd6, 1'b0, 6'd0, 1'b1, "clr");
  endtask

  task automatic test_large_amounts();
    send(3'd3, 3'd7, 1'b1, 6'b000001);
    check_stream(3'd3, 3'd7, 1'b1, 6'b000001, 1'b1, "ror7");
    n_checks++;
    if (bench_sr !== 6'b100000) begin
      n_fail++;
      $display("FAIL ror7_const: got %b want 100000", bench_sr);
    end
    send(3'd2, 3'd6, 1'b1, 6'b111111);
    check_stream(3'd2, 3'd6, 1'b1, 6'b111111, 1'b1, "shl6");
    n_checks++;
    if (bench_sr !== 6'b000000) begin
      n_fail++;
      $display("FAIL shl6_const: got %b want 000000", bench_sr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [2:0] ka, aa, kb, ab;
      logic la, lb;
      logic [5:0] da, db;
      ka = (i == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      aa = (i == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      la = 1'($urandom_range(0, 1));
      da = 6'($urandom_range(0, 63));
      kb = (i == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      ab = (i == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      lb = 1'($urandom_range(0, 1));
      db = 6'($urandom_range(0, 63));
      send(ka, aa, la, da);
      #1;
      cmd_kind = kb;
      cmd_amt = ab;
      cmd_load = lb;
      cmd_data = db;
      check_stream(ka, aa, la, da, 1'b0, "b2b_first");
      send(kb, ab, lb, db);
      check_stream(kb, ab, lb, db, 1'b1, "b2b_second");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] k, a;
      logic l;
      logic [5:0] d;
      k = 3'($urandom_range(0, 7));
      a = 3'($urandom_range(0, 7));
      l = 1'($urandom_range(0, 1));
      d = 6'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(k, a, l, d);
      check_stream(k, a, l, d, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_load_shr();
    test_zero_steps();
    test_large_amounts();
    test_back_to_back();
    test_random();
    test_reset_mid_command();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
